// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer voice path: command field layout,
// allocator FSM encoding and release-command construction.
package synth_pkg;

  localparam int GATE_BIT = 15;
  localparam int VEL_MSB  = 14;
  localparam int VEL_LSB  = 8;
  localparam int NOTE_MSB = 6;
  localparam int NOTE_LSB = 0;
  localparam int NOTE_W   = NOTE_MSB - NOTE_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  // A release keeps the note so the bank can find it, with gate and velocity cleared.
  function automatic logic [15:0] release_data(input logic [NOTE_W-1:0] note);
    logic [15:0] d;
    d = '0;
    d[NOTE_MSB:NOTE_LSB] = note;
    return d;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Command intake and bank-command handshakes between the write register,
// the voice allocator and bank_manager.
interface voice_allocator_if #(
  parameter int IDX_W = 4
);
  logic             i_cmd_valid;
  logic [15:0]      i_cmd_data;
  logic             o_cmd_ready;
  logic             o_bank_valid;
  logic [IDX_W-1:0] o_bank_idx;
  logic [15:0]      o_bank_data;
  logic             i_bank_ready;

  modport slave (
    input  i_cmd_valid, i_cmd_data, i_bank_ready,
    output o_cmd_ready, o_bank_valid, o_bank_idx, o_bank_data
  );

  modport master (
    output i_cmd_valid, i_cmd_data, i_bank_ready,
    input  o_cmd_ready, o_bank_valid, o_bank_idx, o_bank_data
  );
endinterface

// File: rtl/voice_allocator_voice_select.sv
// Parallel search over the voice table: note match, first free voice and
// oldest voice, each resolved toward the lowest index.
module voice_select
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = 4,
  parameter int AGE_W      = 8
) (
  input  logic [NUM_VOICES-1:0]             active,
  input  logic [NUM_VOICES-1:0][NOTE_W-1:0] notes,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0]  ages,
  input  logic [NOTE_W-1:0]                 cmd_note,
  output logic                              match_hit,
  output logic [IDX_W-1:0]                  match_idx,
  output logic                              free_hit,
  output logic [IDX_W-1:0]                  free_idx,
  output logic [IDX_W-1:0]                  oldest_idx
);

  logic [AGE_W-1:0] best_age;

  always_comb begin
    match_hit  = 1'b0;
    match_idx  = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    best_age   = ages[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!match_hit && active[v] && (notes[v] == cmd_note)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(v);
      end
      if (!free_hit && !active[v]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(v);
      end
      // Strict compare keeps the lowest index on equal ages.
      if (ages[v] > best_age) begin
        best_age   = ages[v];
        oldest_idx = IDX_W'(v);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Maps note on/off commands onto bank_manager voices (retrigger, free or
// steal-oldest) and issues one-shot bank commands, plus an all-off flush.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = 4,
  parameter int AGE_W      = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  voice_allocator_if.slave      bus,
  input  logic                  i_all_off,
  output logic [NUM_VOICES-1:0] o_active_mask,
  output logic [CNT_W-1:0]      o_steal_cnt,
  output logic [CNT_W-1:0]      o_drop_cnt
);

  state_t                            state, state_d;
  logic                              run_q;
  logic [15:0]                       cmd_q;
  logic [NUM_VOICES-1:0]             active;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_tbl;
  logic [NUM_VOICES-1:0][AGE_W-1:0]  age_tbl;
  logic [NUM_VOICES-1:0]             mask_q;
  logic [IDX_W-1:0]                  bank_idx_q, scan_idx, tgt;
  logic [15:0]                       bank_data_q;
  logic [CNT_W-1:0]                  steal_cnt, drop_cnt;

  logic             match_hit, free_hit;
  logic [IDX_W-1:0] match_idx, free_idx, oldest_idx;
  logic take_cmd, start_flush, commit_on, commit_off, steal, drop, flush_clear, scan_adv;

  voice_select #(.NUM_VOICES(NUM_VOICES), .IDX_W(IDX_W), .AGE_W(AGE_W)) u_sel (
    .active    (active),
    .notes     (note_tbl),
    .ages      (age_tbl),
    .cmd_note  (cmd_q[NOTE_MSB:NOTE_LSB]),
    .match_hit (match_hit),
    .match_idx (match_idx),
    .free_hit  (free_hit),
    .free_idx  (free_idx),
    .oldest_idx(oldest_idx)
  );

  assign tgt = (match_hit || !cmd_q[GATE_BIT]) ? match_idx :
               free_hit ? free_idx : oldest_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d          = state;
    take_cmd         = 1'b0;
    start_flush      = 1'b0;
    commit_on        = 1'b0;
    commit_off       = 1'b0;
    steal            = 1'b0;
    drop             = 1'b0;
    flush_clear      = 1'b0;
    scan_adv         = 1'b0;
    bus.o_cmd_ready  = 1'b0;
    bus.o_bank_valid = 1'b0;
    bus.o_bank_idx   = '0;
    bus.o_bank_data  = '0;
    case (state)
      ST_IDLE: begin
        // run_q holds intake off until the first clock after reset release.
        if (run_q) begin
          bus.o_cmd_ready = !i_all_off;
          if (i_all_off) begin
            start_flush = 1'b1;
            state_d     = ST_FLUSH;
          end else if (bus.i_cmd_valid) begin
            take_cmd = 1'b1;
            state_d  = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        if (cmd_q[GATE_BIT]) begin
          commit_on = 1'b1;
          steal     = !match_hit && !free_hit;
          state_d   = ST_ISSUE;
        end else if (match_hit) begin
          commit_off = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          drop    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        bus.o_bank_valid = 1'b1;
        bus.o_bank_idx   = bank_idx_q;
        bus.o_bank_data  = bank_data_q;
        if (bus.i_bank_ready) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (active[scan_idx]) begin
          bus.o_bank_valid = 1'b1;
          bus.o_bank_idx   = scan_idx;
          bus.o_bank_data  = release_data(note_tbl[scan_idx]);
          flush_clear      = bus.i_bank_ready;
          scan_adv         = bus.i_bank_ready;
        end else begin
          scan_adv = 1'b1;
        end
        if (scan_adv && (scan_idx == IDX_W'(NUM_VOICES - 1))) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q       <= 1'b0;
      cmd_q       <= '0;
      active      <= '0;
      note_tbl    <= '0;
      age_tbl     <= '0;
      mask_q      <= '0;
      bank_idx_q  <= '0;
      bank_data_q <= '0;
      scan_idx    <= '0;
      steal_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      run_q  <= 1'b1;
      mask_q <= active;
      if (take_cmd) cmd_q <= bus.i_cmd_data;
      if (start_flush)   scan_idx <= '0;
      else if (scan_adv) scan_idx <= scan_idx + 1'b1;
      if (commit_on) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (IDX_W'(v) == tgt) begin
            active[v]   <= 1'b1;
            note_tbl[v] <= cmd_q[NOTE_MSB:NOTE_LSB];
            age_tbl[v]  <= '0;
          end else if (active[v] && (age_tbl[v] != '1)) begin
            age_tbl[v] <= age_tbl[v] + 1'b1;
          end
        end
        bank_idx_q  <= tgt;
        bank_data_q <= cmd_q;
      end
      if (commit_off) begin
        active[tgt] <= 1'b0;
        bank_idx_q  <= tgt;
        bank_data_q <= release_data(cmd_q[NOTE_MSB:NOTE_LSB]);
      end
      if (flush_clear) active[scan_idx] <= 1'b0;
      if (steal && (steal_cnt != '1)) steal_cnt <= steal_cnt + 1'b1;
      if (drop && (drop_cnt != '1))   drop_cnt  <= drop_cnt + 1'b1;
    end
  end

  assign o_active_mask = mask_q;
  assign o_steal_cnt   = steal_cnt;
  assign o_drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: bank commands are predicted into a
// queue as stimulus is driven and matched as the allocator issues them.
module tb_voice_allocator;

  localparam int NV    = 4;
  localparam int IDX_W = 4;
  localparam int AGE_W = 8;
  localparam int CNT_W = 8;

  logic            clk;
  logic            reset;
  logic            all_off;
  logic [NV-1:0]   active_mask;
  logic [CNT_W-1:0] steal_cnt, drop_cnt;

  int vectors;
  int miscompares;
  logic [IDX_W+15:0] exp_q[$];

  voice_allocator_if #(.IDX_W(IDX_W)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .IDX_W(IDX_W), .AGE_W(AGE_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .i_all_off    (all_off),
    .o_active_mask(active_mask),
    .o_steal_cnt  (steal_cnt),
    .o_drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bank(input logic [IDX_W-1:0] idx, input logic [15:0] data);
    exp_q.push_back({idx, data});
  endtask

  // Wait (bounded) for intake, then present one command for a single cycle.
  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    while (bus.o_cmd_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", {31'd0, bus.o_cmd_ready}, 32'd1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_data  = d;
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  // Scoreboard: every completed bank handshake must match the oldest prediction.
  always @(negedge clk) begin
    if (bus.o_bank_valid === 1'b1 && bus.i_bank_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bank_cmd", {12'd0, bus.o_bank_idx, bus.o_bank_data}, 32'hFFFF_FFFF);
      end else begin
        chk("bank_cmd", {12'd0, bus.o_bank_idx, bus.o_bank_data}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b0;
    all_off         = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_data  = '0;
    bus.i_bank_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_cmd_ready", {31'd0, bus.o_cmd_ready}, 32'd0);
    chk("rst_bank_valid", {31'd0, bus.o_bank_valid}, 32'd0);
    chk("rst_mask", {28'd0, active_mask}, 32'd0);
    chk("rst_steal", {24'd0, steal_cnt}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // First note-on: valid two cycles after acceptance
    expect_bank(4'd0, 16'h8A3C);
    send(16'h8A3C);
    chk("lat_lookup_valid", {31'd0, bus.o_bank_valid}, 32'd0);
    tick();
    chk("lat_issue_valid", {31'd0, bus.o_bank_valid}, 32'd1);
    chk("lat_issue_idx", {28'd0, bus.o_bank_idx}, 32'd0);
    chk("lat_issue_data", {16'd0, bus.o_bank_data}, 32'h8A3C);
    repeat (3) tick();
    chk("mask_first_on", {28'd0, active_mask}, 32'h1);
    expect_bank(4'd0, 16'h003C);
    send(16'h003C);
    repeat (4) tick();
    chk("mask_first_off", {28'd0, active_mask}, 32'h0);

    // Five note-ons on four voices: the fifth steals voice 0
    for (int k = 0; k < 4; k++) begin
      expect_bank(IDX_W'(k), 16'hC03C + 16'(k));
      send(16'hC03C + 16'(k));
    end
    expect_bank(4'd0, 16'hC040);
    send(16'hC040);
    repeat (4) tick();
    chk("steal_cnt", {24'd0, steal_cnt}, 32'd1);
    chk("steal_mask", {28'd0, active_mask}, 32'hF);
    expect_bank(4'd1, 16'h003D); send(16'h003D);
    expect_bank(4'd2, 16'h003E); send(16'h003E);
    expect_bank(4'd3, 16'h003F); send(16'h003F);
    expect_bank(4'd0, 16'h0040); send(16'h0040);
    repeat (4) tick();
    chk("steal_clean_mask", {28'd0, active_mask}, 32'h0);

    // Retrigger of the same note
    expect_bank(4'd0, 16'hC03C); send(16'hC03C);
    expect_bank(4'd0, 16'h8A3C); send(16'h8A3C);
    repeat (4) tick();
    chk("retrig_mask", {28'd0, active_mask}, 32'h1);
    chk("retrig_no_steal", {24'd0, steal_cnt}, 32'd1);
    expect_bank(4'd0, 16'h003C); send(16'h003C);
    repeat (4) tick();
    chk("retrig_off_mask", {28'd0, active_mask}, 32'h0);

    // Unmatched note-off is dropped
    send(16'h0046);
    chk("drop_ready_lookup", {31'd0, bus.o_cmd_ready}, 32'd0);
    tick();
    chk("drop_ready_back", {31'd0, bus.o_cmd_ready}, 32'd1);
    chk("drop_no_valid", {31'd0, bus.o_bank_valid}, 32'd0);
    chk("drop_cnt", {24'd0, drop_cnt}, 32'd1);

    // Back-pressure: command held while bank_manager is not ready
    bus.i_bank_ready = 1'b0;
    expect_bank(4'd0, 16'h8A3C);
    send(16'h8A3C);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", {31'd0, bus.o_bank_valid}, 32'd1);
      chk("hold_idx", {28'd0, bus.o_bank_idx}, 32'd0);
      chk("hold_data", {16'd0, bus.o_bank_data}, 32'h8A3C);
      chk("hold_cmd_ready", {31'd0, bus.o_cmd_ready}, 32'd0);
      tick();
    end
    bus.i_bank_ready = 1'b1;
    tick();
    chk("hold_released", {31'd0, bus.o_bank_valid}, 32'd0);

    // Voices 0 and 2 active, then all-off collides with a command
    expect_bank(4'd1, 16'hC03D); send(16'hC03D);
    expect_bank(4'd2, 16'hC03E); send(16'hC03E);
    expect_bank(4'd1, 16'h003D); send(16'h003D);
    repeat (4) tick();
    chk("flush_pre_mask", {28'd0, active_mask}, 32'h5);
    expect_bank(4'd0, 16'h003C);
    expect_bank(4'd2, 16'h003E);
    all_off         = 1'b1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_data  = 16'h8A50;
    #1;
    chk("flush_cmd_ready", {31'd0, bus.o_cmd_ready}, 32'd0);
    tick();
    all_off         = 1'b0;
    bus.i_cmd_valid = 1'b0;
    repeat (10) tick();
    chk("flush_mask", {28'd0, active_mask}, 32'h0);
    chk("flush_queue_empty", exp_q.size(), 32'd0);
    chk("flush_idle_ready", {31'd0, bus.o_cmd_ready}, 32'd1);

    // Asynchronous reset while a command is held in ISSUE
    bus.i_bank_ready = 1'b0;
    send(16'h8A3C);
    tick();
    chk("rst_mid_pre_valid", {31'd0, bus.o_bank_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, bus.o_bank_valid}, 32'd0);
    chk("rst_mid_steal", {24'd0, steal_cnt}, 32'd0);
    chk("rst_mid_drop", {24'd0, drop_cnt}, 32'd0);
    tick();
    reset = 1'b1;
    bus.i_bank_ready = 1'b1;
    repeat (4) tick();
    chk("rst_mid_mask", {28'd0, active_mask}, 32'h0);
    chk("rst_mid_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
